// File: rtl/aram_arbiter.sv
// Audio RAM arbiter: DSP / SPC700 CPU / host loader share one single-port RAM.
// One access per cycle, host starvation guard, exclusive host lock for bulk loads.
module aram_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    output logic              dsp_ack,
    output logic              dsp_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    input  logic              host_lock_req,
    output logic              host_lock_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_write,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_read
);

    localparam int CNT_W    = 4;
    localparam int STAGES   = 1;
    localparam int SRC_DSP  = 0;
    localparam int SRC_CPU  = 1;
    localparam int SRC_HOST = 2;

    typedef enum logic [1:0] {SHARED, DRAINING, EXCLUSIVE} lock_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    lock_state_t             state, state_next;
    logic [CNT_W-1:0]        wait_cnt;
    logic [STAGES:0][2:0]    vld_pipe;   // [0]: address cycle, [STAGES]: data cycle
    logic [2:0]              grant;
    logic [2:0]              rd_new;
    acc_t                    win;
    logic                    host_starved;
    logic                    cpu_eligible;

    // Lock FSM
    always_ff @(posedge clock) begin
        if (reset) state <= SHARED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SHARED:    if (host_lock_req) state_next = DRAINING;
            DRAINING: begin
                if (!host_lock_req)
                    state_next = SHARED;
                else if (!vld_pipe[0][SRC_CPU] && !vld_pipe[STAGES][SRC_CPU])
                    state_next = EXCLUSIVE;
            end
            EXCLUSIVE: if (!host_lock_req) state_next = SHARED;
            default:   state_next = SHARED;
        endcase
    end

    // The CPU is shut out in the very cycle the lock is first requested.
    always_comb begin
        host_lock_ack = (state == EXCLUSIVE);
        cpu_eligible  = (state == SHARED) && !host_lock_req;
    end

    // Grant decision
    assign host_starved = (wait_cnt == CNT_W'(HOST_MAX_WAIT));

    always_comb begin
        grant = '0;
        if (!reset) begin
            if (dsp_req)                       grant[SRC_DSP]  = 1'b1;
            else if (host_req && host_starved) grant[SRC_HOST] = 1'b1;
            else if (cpu_req && cpu_eligible)  grant[SRC_CPU]  = 1'b1;
            else if (host_req)                 grant[SRC_HOST] = 1'b1;
        end
    end

    always_comb begin
        win = '{we: 1'b0, addr: dsp_addr, wdata: ram_data_write};
        if (grant[SRC_CPU])
            win = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        else if (grant[SRC_HOST])
            win = '{we: host_we, addr: host_addr, wdata: host_wdata};
    end

    assign rd_new   = grant & {3{~win.we}};
    assign dsp_ack  = grant[SRC_DSP];
    assign cpu_ack  = grant[SRC_CPU];
    assign host_ack = grant[SRC_HOST];

    // RAM command register; address and write data hold across idle cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_address    <= '0;
            ram_data_write <= '0;
            ram_we         <= 1'b0;
        end else begin
            ram_we <= (|grant) & win.we;
            if (|grant)
                ram_address <= win.addr;
            if ((|grant) && win.we)
                ram_data_write <= win.wdata;
        end
    end

    // Read-source pipeline; the last stage lines up with ram_data_read
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_new;
            for (int i = 1; i <= STAGES; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign dsp_rvalid  = vld_pipe[STAGES][SRC_DSP];
    assign cpu_rvalid  = vld_pipe[STAGES][SRC_CPU];
    assign host_rvalid = vld_pipe[STAGES][SRC_HOST];
    assign rdata       = ram_data_read;

    // Host starvation counter, saturating
    always_ff @(posedge clock) begin
        if (reset)
            wait_cnt <= '0;
        else if (host_req && !grant[SRC_HOST]) begin
            if (!host_starved)
                wait_cnt <= wait_cnt + 1'b1;
        end else
            wait_cnt <= '0;
    end

endmodule
